// File: rtl/multiword_add_seq.sv
// multiword_add_seq
//   Multi-precision add/subtract sequencer. A single WIDTH-bit carry adder is
//   reused once per word, least significant word first. The carry between
//   words is held in an internal register.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     operation request, accepted only while ready=1
//   ready     high in IDLE
//   sub       0: a+b+cin, 1: a-b (b inverted, carry-in forced to 1)
//   cin       carry-in for word 0 when sub=0
//   nwords    active word count (0 or >WORDS selects WORDS)
//   a_in      operand a, word k at [k*WIDTH +: WIDTH]
//   b_in      operand b, same layout
//   sum       result; words at or above the active count read 0
//   cout      carry out of the last active word (sub: 1 = no borrow)
//   overflow  signed overflow of the active-width result
//   busy      high while words are being processed
//   done      one-cycle pulse when the result is valid
module multiword_add_seq #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4,
  parameter int NW    = $clog2(WORDS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   ready,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [NW-1:0]          nwords,
  input  logic [WIDTH*WORDS-1:0] a_in,
  input  logic [WIDTH*WORDS-1:0] b_in,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done
);

  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH*WORDS-1:0] a_lat;
  logic [WIDTH*WORDS-1:0] b_lat;
  logic [KW-1:0]          k;
  logic [KW-1:0]          k_last;
  logic [KW-1:0]          n_clamp;
  logic                   carry;
  logic [WIDTH-1:0]       a_word;
  logic [WIDTH-1:0]       b_word;
  logic [WIDTH-1:0]       add_sum;
  logic                   add_cout;
  logic                   accept;
  logic                   last;

  // Index of the last active word; out-of-range counts select the full width.
  always_comb begin
    n_clamp = KW'(WORDS - 1);
    if (nwords != '0 && 32'(nwords) <= WORDS) n_clamp = KW'(nwords - 1'b1);
  end

  assign accept = (state == IDLE) && start;
  assign last   = (k == k_last);

  // Shared carry adder, fed the current word of the latched operands.
  always_comb begin
    a_word = a_lat[k*WIDTH +: WIDTH];
    b_word = b_lat[k*WIDTH +: WIDTH];
    {add_cout, add_sum} = {1'b0, a_word} + {1'b0, b_word} + (WIDTH + 1)'(carry);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, so b is inverted once at accept and the
  // initial carry forced high. k stops at the last word instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_lat    <= '0;
      b_lat    <= '0;
      k        <= '0;
      k_last   <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_lat    <= a_in;
      b_lat    <= sub ? ~b_in : b_in;
      k        <= '0;
      k_last   <= n_clamp;
      carry    <= sub | cin;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN) begin
      sum[k*WIDTH +: WIDTH] <= add_sum;
      carry                 <= add_cout;
      if (last) begin
        cout     <= add_cout;
        // carry into the MSB is a^b^sum at that bit
        overflow <= add_cout ^ (a_word[WIDTH-1] ^ b_word[WIDTH-1] ^ add_sum[WIDTH-1]);
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq
//   Directed bench for multiword_add_seq with WIDTH=32, WORDS=4.
module tb_multiword_add_seq;

  localparam int WIDTH = 32;
  localparam int WORDS = 4;
  localparam int NW    = 3;

  logic                   clk;
  logic                   reset;
  logic                   start;
  logic                   ready;
  logic                   sub;
  logic                   cin;
  logic [NW-1:0]          nwords;
  logic [WIDTH*WORDS-1:0] a_in;
  logic [WIDTH*WORDS-1:0] b_in;
  logic [WIDTH*WORDS-1:0] sum;
  logic                   cout;
  logic                   overflow;
  logic                   busy;
  logic                   done;

  int passed = 0;
  int total  = 0;

  multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS), .NW(NW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ready    (ready),
    .sub      (sub),
    .cin      (cin),
    .nwords   (nwords),
    .a_in     (a_in),
    .b_in     (b_in),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request, accepts it, scrambles the inputs afterwards and
  // counts edges until done (bounded). cyc = edges from accept to done.
  task automatic run_op(input logic s, input logic ci, input logic [NW-1:0] nw,
                        input logic [127:0] a, input logic [127:0] b, output int cyc);
    @(negedge clk);
    sub = s; cin = ci; nwords = nw; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = '1; b_in = 128'h5A5A_5A5A_A5A5_A5A5_1234_5678_9ABC_DEF0;
    sub = ~s; cin = ~ci; nwords = 3'd1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; nwords = '0;
    a_in = '0; b_in = '0;
    #12;
    total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (sum !== '0) $display("FAIL reset_sum got %h want 0", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else passed++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_word;
    int cyc;
    run_op(1'b0, 1'b1, 3'd1, 128'd5, 128'd7, cyc);
    total++; if (cyc !== 1) $display("FAIL w1_latency got %0d want 1", cyc); else passed++;
    total++; if (sum !== 128'd13) $display("FAIL w1_sum got %h want %h", sum, 128'd13); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL w1_cout got %b want 0", cout); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL w1_ovf got %b want 0", overflow); else passed++;
    @(posedge clk); #1;
    total++; if (ready !== 1'b1 || done !== 1'b0)
      $display("FAIL w1_ready_after got ready=%b done=%b want ready=1 done=0", ready, done);
    else passed++;
  endtask

  task automatic test_full_width;
    int cyc;
    run_op(1'b0, 1'b0, 3'd0, '1, 128'd1, cyc);
    total++; if (cyc !== 4) $display("FAIL w4_latency got %0d want 4", cyc); else passed++;
    total++; if (sum !== '0) $display("FAIL w4_sum got %h want 0", sum); else passed++;
    total++; if (cout !== 1'b1) $display("FAIL w4_cout got %b want 1", cout); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL w4_ovf got %b want 0", overflow); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_chain;
    int cyc;
    run_op(1'b0, 1'b0, 3'd2, 128'h0000_0000_FFFF_FFFF, 128'd1, cyc);
    total++; if (cyc !== 2) $display("FAIL w2_latency got %0d want 2", cyc); else passed++;
    total++; if (sum !== 128'h1_0000_0000) $display("FAIL w2_sum got %h want %h", sum, 128'h1_0000_0000); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL w2_cout got %b want 0", cout); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_subtract_borrow;
    int cyc;
    run_op(1'b1, 1'b0, 3'd2, 128'd0, 128'd1, cyc);
    total++; if (cyc !== 2) $display("FAIL sub2_latency got %0d want 2", cyc); else passed++;
    total++; if (sum !== 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF)
      $display("FAIL sub2_sum got %h want %h", sum, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    else passed++;
    total++; if (cout !== 1'b0) $display("FAIL sub2_cout got %b want 0", cout); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL sub2_ovf got %b want 0", overflow); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    int cyc;
    // previous result left words 0-1 set; the accept must clear word 1
    run_op(1'b0, 1'b0, 3'd1, 128'h7FFF_FFFF, 128'd1, cyc);
    total++; if (sum !== 128'h8000_0000) $display("FAIL ovf_add_sum got %h want %h", sum, 128'h8000_0000); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_add_ovf got %b want 1", overflow); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL ovf_add_cout got %b want 0", cout); else passed++;
    @(posedge clk); #1;
    run_op(1'b1, 1'b1, 3'd1, 128'h8000_0000, 128'd1, cyc);
    total++; if (sum !== 128'h7FFF_FFFF) $display("FAIL ovf_sub_sum got %h want %h", sum, 128'h7FFF_FFFF); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sub_ovf got %b want 1", overflow); else passed++;
    total++; if (cout !== 1'b1) $display("FAIL ovf_sub_cout got %b want 1", cout); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; nwords = 3'd1; a_in = 128'd1; b_in = 128'd2; start = 1'b1;
    @(posedge clk); #1;  // E0
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy_e0 got %b want 1", busy); else passed++;
    @(posedge clk); #1;  // E1
    total++; if (done !== 1'b1 || ready !== 1'b0)
      $display("FAIL b2b_done got done=%b ready=%b want done=1 ready=0", done, ready);
    else passed++;
    @(posedge clk); #1;  // E2: start seen during done is ignored
    total++; if (ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL b2b_ignored got ready=%b busy=%b want ready=1 busy=0", ready, busy);
    else passed++;
    a_in = 128'd10; b_in = 128'd20;
    @(posedge clk); #1;  // E3: accepted
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", busy); else passed++;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (cyc !== 1 || sum !== 128'd30)
      $display("FAIL b2b_second got cyc=%0d sum=%h want cyc=1 sum=%h", cyc, sum, 128'd30);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int cyc;
    logic saw_done;
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; nwords = 3'd4;
    a_in = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
    b_in = 128'h0000_0028_0000_001E_0000_0014_0000_000A;
    start = 1'b1;
    @(posedge clk); #1;  // E0
    start = 1'b0;
    @(posedge clk); #1;  // E1
    start = 1'b1; a_in = '1; b_in = '1;
    @(posedge clk); #1;  // E2: second start ignored
    start = 1'b0;
    total++; if (busy !== 1'b1 || ready !== 1'b0)
      $display("FAIL abort_restart got busy=%b ready=%b want busy=1 ready=0", busy, ready);
    else passed++;
    total++; if (sum !== 128'h0000_0016_0000_000B)
      $display("FAIL abort_partial got %h want %h", sum, 128'h0000_0016_0000_000B);
    else passed++;
    @(posedge clk); #1;  // E3
    reset = 1'b0;
    #1;
    total++; if (sum !== '0 || cout !== 1'b0 || overflow !== 1'b0)
      $display("FAIL abort_clear got sum=%h cout=%b ovf=%b want all 0", sum, cout, overflow);
    else passed++;
    total++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_ctrl got ready=%b busy=%b done=%b want 1 0 0", ready, busy, done);
    else passed++;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) $display("FAIL abort_no_done got done pulse=%b want 0", saw_done); else passed++;
    run_op(1'b0, 1'b1, 3'd1, 128'd5, 128'd7, cyc);
    total++; if (cyc !== 1 || sum !== 128'd13)
      $display("FAIL abort_recover got cyc=%0d sum=%h want cyc=1 sum=%h", cyc, sum, 128'd13);
    else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_full_width;
    test_carry_chain;
    test_subtract_borrow;
    test_overflow;
    test_back_to_back;
    test_abort;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
